// File: rtl/reg_slice_chain_pkg.sv
// Shared types and helpers for the valid/ready register slice chain.
package reg_slice_pkg;

    typedef enum logic {SLICE_FWD, SLICE_FULL} reg_slice_mode_e;

    // Items a chain of the given mode and depth can hold at once.
    function automatic int unsigned reg_slice_cap(reg_slice_mode_e mode, int unsigned stages);
        return (mode == SLICE_FULL) ? 2 * stages : stages;
    endfunction

endpackage

// File: rtl/reg_slice_chain_stage.sv
// One valid/ready register slice: forward-registered or full skid buffer.
module reg_slice_stage
    import reg_slice_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter reg_slice_mode_e       MODE       = SLICE_FULL,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  up_valid,
    output logic                  up_ready,
    input  logic [DATA_WIDTH-1:0] up_dat,
    output logic                  dn_valid,
    input  logic                  dn_ready,
    output logic [DATA_WIDTH-1:0] dn_dat
);

    logic                  vld_q;
    logic [DATA_WIDTH-1:0] dat_q;

    assign dn_valid = vld_q;
    assign dn_dat   = dat_q;

    generate
        if (MODE == SLICE_FWD) begin : g_fwd
            assign up_ready = ~vld_q | dn_ready;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q <= 1'b0;
                    dat_q <= RESET_VAL;
                end else if (flush) begin
                    vld_q <= 1'b0;
                end else if (up_ready) begin
                    vld_q <= up_valid;
                    if (up_valid) dat_q <= up_dat;
                end
            end
        end else begin : g_full
            logic                  skid_vld_q;
            logic [DATA_WIDTH-1:0] skid_dat_q;
            logic                  accept;
            logic                  drain;

            // Ready comes straight from a flop so no combinational path crosses the slice.
            assign up_ready = ~skid_vld_q;
            assign accept   = up_valid & up_ready;
            assign drain    = vld_q & dn_ready;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q      <= 1'b0;
                    dat_q      <= RESET_VAL;
                    skid_vld_q <= 1'b0;
                    skid_dat_q <= RESET_VAL;
                end else if (flush) begin
                    vld_q      <= 1'b0;
                    skid_vld_q <= 1'b0;
                end else if (~vld_q | drain) begin
                    if (skid_vld_q) begin
                        vld_q      <= 1'b1;
                        dat_q      <= skid_dat_q;
                        skid_vld_q <= 1'b0;
                    end else begin
                        vld_q <= accept;
                        if (accept) dat_q <= up_dat;
                    end
                end else if (accept) begin
                    skid_vld_q <= 1'b1;
                    skid_dat_q <= up_dat;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/reg_slice_chain.sv
// Chain of STAGES register slices with flush and occupancy count; STAGES=0 is a wire.
module reg_slice_chain
    import reg_slice_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           STAGES     = 1,
    parameter reg_slice_mode_e       MODE       = SLICE_FULL,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0,
    localparam int unsigned          OCC_W      = (STAGES == 0) ? 1 : $clog2(2 * STAGES + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  flush_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    input  logic [DATA_WIDTH-1:0] s_dat_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DATA_WIDTH-1:0] m_dat_o,
    output logic [OCC_W-1:0]      occ_o
);

    localparam int unsigned CAP = reg_slice_cap(MODE, STAGES);

    generate
        if (STAGES == 0) begin : g_bypass
            assign m_valid_o = s_valid_i;
            assign m_dat_o   = s_dat_i;
            assign s_ready_o = m_ready_i;
            assign occ_o     = '0;
        end else begin : g_chain
            logic                  vld [STAGES+1];
            logic                  rdy [STAGES+1];
            logic [DATA_WIDTH-1:0] dat [STAGES+1];
            logic [OCC_W-1:0]      occ_q;
            logic                  accept;
            logic                  xfer;

            assign vld[0]      = s_valid_i;
            assign dat[0]      = s_dat_i;
            assign rdy[STAGES] = m_ready_i;

            for (genvar k = 0; k < STAGES; k++) begin : g_stage
                reg_slice_stage #(
                    .DATA_WIDTH (DATA_WIDTH),
                    .MODE       (MODE),
                    .RESET_VAL  (RESET_VAL)
                ) u_stage (
                    .clk      (clk_i),
                    .rst_n    (rst_n_i),
                    .flush    (flush_i),
                    .up_valid (vld[k]),
                    .up_ready (rdy[k]),
                    .up_dat   (dat[k]),
                    .dn_valid (vld[k+1]),
                    .dn_ready (rdy[k+1]),
                    .dn_dat   (dat[k+1])
                );
            end

            // Blocking ready during flush keeps a new item from being swallowed by the clear.
            assign s_ready_o = rdy[0] & ~flush_i;
            assign m_valid_o = vld[STAGES];
            assign m_dat_o   = dat[STAGES];
            assign accept    = s_valid_i & s_ready_o;
            assign xfer      = m_valid_o & m_ready_i;
            assign occ_o     = occ_q;

            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    occ_q <= '0;
                end else if (flush_i) begin
                    occ_q <= '0;
                end else if (accept & ~xfer) begin
                    occ_q <= occ_q + OCC_W'(1);
                end else if (~accept & xfer) begin
                    occ_q <= occ_q - OCC_W'(1);
                end
            end

`ifndef SV_ASSRT_DISABLE
            a_ctrl_known : assert property (@(posedge clk_i) disable iff (!rst_n_i)
                !$isunknown({s_valid_i, m_ready_i, flush_i}));
            a_stall_stable : assert property (@(posedge clk_i) disable iff (!rst_n_i)
                (m_valid_o & ~m_ready_i & ~flush_i) |=> (m_valid_o && $stable(m_dat_o)));
            a_occ_cap : assert property (@(posedge clk_i) disable iff (!rst_n_i)
                32'(occ_q) <= CAP);
`endif
        end
    endgenerate

endmodule

// File: doc/reg_slice_chain.md
Name: reg_slice_chain

Overview:
- Parametrised valid/ready pipeline register chain: STAGES back-to-back register slices between an upstream source and a downstream sink.
- Each slice is either forward-registered (FWD) or a fully registered skid buffer (FULL).
- Generalises the plain enable-register primitives with backpressure, synchronous flush and an occupancy count.
- Used to break timing paths on bus and stream interfaces (AXI/APB channels, core-to-peripheral streams).

Parameters:
- DATA_WIDTH, 32, payload width in bits (>=1).
- STAGES, 1, number of slices (0..8); 0 = combinational wire-through.
- MODE, SLICE_FULL, slice type for all stages: SLICE_FWD or SLICE_FULL.
- RESET_VAL, '0, reset value of every payload register (DATA_WIDTH bits).

Ports:
- clk_i  in  1  clock; all state on posedge.
- rst_n_i  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous flush; drops all held items.
- s_valid_i  in  1  upstream valid.
- s_ready_o  out  1  upstream ready.
- s_dat_i  in  DATA_WIDTH  upstream payload.
- m_valid_o  out  1  downstream valid.
- m_ready_i  in  1  downstream ready.
- m_dat_o  out  DATA_WIDTH  downstream payload.
- occ_o  out  OCC_W = $clog2(2*STAGES+1) (min 1)  number of items held.

Behaviour:
- Transfers: upstream accept = s_valid_i & s_ready_o; downstream transfer = m_valid_o & m_ready_i.
- Reset (async assert, sync-released by the reset source):
  - all valid and skid flags 0; payload registers RESET_VAL; occ_o 0.
  - m_valid_o 0; m_dat_o RESET_VAL; s_ready_o 1.
- FWD slice:
  - capacity 1; latency 1 cycle.
  - up_ready = ~vld_q | dn_ready (combinational through the slice).
  - When up_ready: vld_q <= up_valid. Payload loads only on up_valid & up_ready; otherwise it holds.
- FULL slice:
  - capacity 2 (main + skid); latency 1 cycle; up_ready = ~skid_vld_q (registered).
  - Main empty or draining: input goes to main.
  - Main full and not draining while up_ready: input goes to skid.
  - On drain with skid full: skid moves to main, skid cleared.
  - Full throughput with no combinational ready path.
- Chain: stage k downstream side drives stage k+1 upstream side.
  - Total latency is STAGES cycles with no backpressure.
  - Total capacity is STAGES (FWD) or 2*STAGES (FULL).
- STAGES=0: m_valid_o = s_valid_i, m_dat_o = s_dat_i, s_ready_o = m_ready_i, occ_o = 0.
- Stability: while m_valid_o & ~m_ready_i, m_valid_o and m_dat_o hold unchanged.
- Flush:
  - flush_i high: s_ready_o forced 0, so no accept occurs.
  - A downstream transfer in the flush cycle completes normally.
  - Next cycle: all valid/skid flags 0, occ_o 0. Payload registers keep their values (not cleared).
  - Flush has priority over every other update.
- occ_o: +1 on accept, -1 on downstream transfer, unchanged on both or neither, 0 after flush.
  - Never exceeds capacity; never underflows.
- Simultaneous accept and transfer on a full FULL chain: legal only because s_ready_o is 0 when the skid is full. No accept occurs, so no overflow.
- Reset mid-transfer: all items lost; outputs return to reset values immediately, independent of the clock.
- X checking (unless SV_ASSRT_DISABLE):
  - s_valid_i, m_ready_i and flush_i must not be X at posedge.
  - Assertion: m_dat_o stable under stall.
  - Assertion: occ_o <= capacity.

Decomposition:
- Package reg_slice_pkg:
  - typedef enum logic {SLICE_FWD, SLICE_FULL} reg_slice_mode_e;
  - function reg_slice_cap(mode, stages), returning the capacity for occ width and assertions.
- Sub-module reg_slice_stage (one slice with MODE, DATA_WIDTH, RESET_VAL; includes flush).
- Top generates the STAGES instances plus the occupancy counter and the STAGES=0 bypass.

Test Plan:
- Reset release, STAGES=2 FULL, DATA_WIDTH=32, RESET_VAL=32'hDEAD_BEEF:
  - m_valid_o=0, m_dat_o=32'hDEAD_BEEF, s_ready_o=1, occ_o=0.
- Streaming, STAGES=3 FULL, m_ready_i=1, inputs 1,2,3,4 on consecutive cycles:
  - outputs 1,2,3,4 on consecutive cycles, first output 3 cycles after first accept.
  - s_ready_o stays 1 throughout.
- Backpressure, STAGES=2 FULL, m_ready_i=0, s_valid_i=1 with values 10..15:
  - exactly 4 accepted (10..13); s_ready_o drops to 0; occ_o=4; m_dat_o=10 stable.
  - Releasing m_ready_i drains 10,11,12,13 in order.
- FWD mode, STAGES=1, slice holding item A, m_ready_i=1 and s_valid_i=1 with B in the same cycle:
  - B accepted with no bubble; m_dat_o=B next cycle; occ_o=1.
- Flush, STAGES=2 FULL, occ_o=3, flush_i=1 with m_ready_i=1 and s_valid_i=1:
  - head item delivered; input not accepted; next cycle m_valid_o=0, occ_o=0, s_ready_o=1.
- Mid-stream async reset pulse between clock edges, STAGES=2 FWD:
  - m_valid_o and occ_o go to 0 immediately; traffic resumes correctly after release.
- STAGES=0:
  - m_dat_o follows s_dat_i combinationally; s_ready_o mirrors m_ready_i; occ_o=0.
